record: RTL and testbench
=========================

RECORD -- requirements
Module: record

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, meaning the SRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the sample width and SRAM word width.
REQ-003 i_clk  in  1  single clock, the audio BCLK; all logic on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_start, i_pause, i_stop  in  1 each  one-cycle control pulses.
REQ-006 i_start_addr  in  ADDR_W  first SRAM address to write.
REQ-007 i_ADCLRC  in  1  ADC frame clock; low = left channel.
REQ-008 i_ADCDAT  in  1  ADC serial data, MSB first, I2S one-BCLK delay.
REQ-009 o_sram_addr  out  ADDR_W  current write address.
REQ-010 o_sram_dq  out  DATA_W  write data.
REQ-011 o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active-low.
REQ-012 o_end_addr  out  ADDR_W  last address written in the latest recording.
REQ-013 o_finish  out  1  one-cycle pulse when recording ends.
REQ-014 o_state  out  3  current FSM state encoding.

Function
REQ-015 FSM states SHALL be IDLE=0, WAIT_LRC=1, SHIFT=2, WRITE=3, PAUSED=4, DONE=5.
REQ-016 IDLE + i_start (and no i_stop) -> WAIT_LRC; load o_sram_addr=i_start_addr.
REQ-017 i_ADCLRC is registered each cycle; falling edge = registered 1, current 0.
REQ-018 WAIT_LRC + ADCLRC falling edge -> SHIFT; that edge cycle is the delay slot, no bit captured.
REQ-019 SHIFT captures i_ADCDAT on 16 consecutive rising edges following the delay slot, MSB first, into a shift register; after bit 0 -> WRITE.
REQ-020 WRITE lasts exactly one cycle: o_sram_we_n=0, o_sram_dq=captured sample, o_sram_addr unchanged.
REQ-021 Cycle after WRITE: o_sram_addr increments by 1, o_end_addr takes the written address, state -> WAIT_LRC (right-channel bits ignored).
REQ-022 o_sram_ce_n, o_sram_lb_n, o_sram_ub_n SHALL be 0 in every state except IDLE; o_sram_oe_n SHALL be 1 always; o_sram_we_n SHALL be 1 outside WRITE.
REQ-023 i_pause in WAIT_LRC -> PAUSED; i_pause in SHIFT/WRITE sets a pending flag honoured on return to WAIT_LRC (no partial sample lost).
REQ-024 PAUSED + i_start or i_pause -> WAIT_LRC, address preserved.
REQ-025 i_stop in any non-IDLE state -> DONE next cycle; partial sample in SHIFT discarded; a WRITE in progress completes that cycle.
REQ-026 Write to address 2^ADDR_W-1 SHALL force DONE after it (no wrap-around).
REQ-027 DONE lasts one cycle with o_finish=1, then -> IDLE.
REQ-028 Simultaneous i_start and i_stop in IDLE: stop wins, remain IDLE; i_stop has priority over i_pause everywhere.

Reset
REQ-029 On i_rst_n=0 asynchronously: state IDLE, o_sram_addr=0, o_sram_dq=0, o_end_addr=0, o_finish=0, shift register and pause flag cleared, strobes per REQ-022 for IDLE.
REQ-030 Reset mid-recording SHALL abort without o_finish pulse and without SRAM write.

Configuration
REQ-031 With RECORD_PEAK_EN defined, the block SHALL add output o_peak (DATA_W-1 bits) holding the maximum absolute value of stored samples since the last i_start (saturating |-32768| to 32767); without it, no o_peak port and no peak logic.

Verification
REQ-032 start_addr=0, ADC frame sends 0xAC54 left -> one write, addr 0, dq 0xAC54, we_n low one cycle, then addr=1.
REQ-033 Three frames 0x0001, 0x8000, 0xFFFF then i_stop -> addrs 0..2 written in order; o_end_addr=2; o_finish one pulse.
REQ-034 i_pause mid-SHIFT of 0x1234 -> 0x1234 still written, then PAUSED; next frame ignored; i_start resumes at next address.
REQ-035 start_addr=0xFFFFF, one frame 0x5555 -> write at 0xFFFFF, o_finish pulse, IDLE, o_end_addr=0xFFFFF.
REQ-036 i_rst_n asserted during SHIFT -> all outputs at reset values immediately, no write, no o_finish; i_start+i_stop same cycle in IDLE -> stays IDLE.
REQ-037 With RECORD_PEAK_EN: samples 0x0100, 0xFE00, 0x8000 -> o_peak 0x0100, 0x0200, 0x7FFF.

Source files
------------

// File: rtl/record_if.sv
// SRAM write-port bundle for the audio recorder: address, data and the
// active-low strobes. The recorder drives it through the master modport.
interface record_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_sram_dq;
  logic              o_sram_we_n;
  logic              o_sram_ce_n;
  logic              o_sram_oe_n;
  logic              o_sram_lb_n;
  logic              o_sram_ub_n;

  modport master (
    output o_sram_addr, o_sram_dq, o_sram_we_n, o_sram_ce_n,
           o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
  );

  modport slave (
    input  o_sram_addr, o_sram_dq, o_sram_we_n, o_sram_ce_n,
           o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
  );
endinterface

// File: rtl/record.sv
// I2S left-channel recorder: captures one sample per ADC frame and writes it to
// consecutive SRAM addresses. Define RECORD_PEAK_EN to add the o_peak tracker.
module record #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_ADCLRC,
  input  logic              i_ADCDAT,
  record_if.master          sram,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_finish,
  output logic [2:0]        o_state
`ifdef RECORD_PEAK_EN
  ,
  output logic [DATA_W-2:0] o_peak
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LRC = 3'd1,
    SHIFT    = 3'd2,
    WRITE    = 3'd3,
    PAUSED   = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state;
  logic              lrc_q;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              pend;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_q;
  logic              we_n_q;
  logic              ce_n_q;
  logic [ADDR_W-1:0] end_addr_q;
  logic              finish_q;

  logic              lrc_fall;
  logic [DATA_W-1:0] sample_nxt;

  assign lrc_fall   = lrc_q & ~i_ADCLRC;
  assign sample_nxt = {shreg[DATA_W-2:0], i_ADCDAT};

  assign sram.o_sram_addr = addr_q;
  assign sram.o_sram_dq   = dq_q;
  assign sram.o_sram_we_n = we_n_q;
  assign sram.o_sram_ce_n = ce_n_q;
  assign sram.o_sram_lb_n = ce_n_q;
  assign sram.o_sram_ub_n = ce_n_q;
  assign sram.o_sram_oe_n = 1'b1;   // write-only port, outputs never enabled
  assign o_end_addr       = end_addr_q;
  assign o_finish         = finish_q;
  assign o_state          = state;

  // NOTE: every register here is state, so it is written with <= only; blocking
  // assignments would let later statements see the new value mid-edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      lrc_q      <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      pend       <= 1'b0;
      addr_q     <= '0;
      dq_q       <= '0;
      we_n_q     <= 1'b1;
      ce_n_q     <= 1'b1;
      end_addr_q <= '0;
      finish_q   <= 1'b0;
    end else begin
      lrc_q    <= i_ADCLRC;
      finish_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !i_stop) begin
            state  <= WAIT_LRC;
            addr_q <= i_start_addr;
            pend   <= 1'b0;
            ce_n_q <= 1'b0;
          end
        end
        WAIT_LRC: begin
          if (i_stop) begin
            state    <= DONE;
            finish_q <= 1'b1;
          end else if (i_pause) begin
            state <= PAUSED;
          end else if (lrc_fall) begin
            // The falling-edge cycle is the I2S delay slot: no bit yet.
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (i_stop) begin
            state    <= DONE;
            finish_q <= 1'b1;
          end else begin
            shreg   <= sample_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (i_pause) pend <= 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state  <= WRITE;
              we_n_q <= 1'b0;
              dq_q   <= sample_nxt;
            end
          end
        end
        WRITE: begin
          we_n_q     <= 1'b1;
          end_addr_q <= addr_q;
          if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
          if (i_stop || addr_q == ADDR_MAX) begin
            state    <= DONE;
            finish_q <= 1'b1;
          end else if (pend || i_pause) begin
            state <= PAUSED;
            pend  <= 1'b0;
          end else begin
            state <= WAIT_LRC;
          end
        end
        PAUSED: begin
          if (i_stop) begin
            state    <= DONE;
            finish_q <= 1'b1;
          end else if (i_start || i_pause) begin
            state <= WAIT_LRC;
          end
        end
        DONE: begin
          state  <= IDLE;
          ce_n_q <= 1'b1;
          pend   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ce_n_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef RECORD_PEAK_EN
  logic [DATA_W-1:0] neg;
  logic [DATA_W-2:0] mag;
  logic [DATA_W-2:0] peak_q;

  // Magnitude of the sample being written; the most negative code saturates.
  always_comb begin
    neg = -dq_q;
    mag = dq_q[DATA_W-2:0];
    if (dq_q[DATA_W-1]) begin
      if (dq_q[DATA_W-2:0] == '0) mag = '1;
      else                        mag = neg[DATA_W-2:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak_q <= '0;
    end else if (state == IDLE && i_start && !i_stop) begin
      peak_q <= '0;
    end else if (state == WRITE && mag > peak_q) begin
      peak_q <= mag;
    end
  end

  assign o_peak = peak_q;
`endif

endmodule

// File: tb/tb_record.sv
// Self-checking bench for record: randomized I2S frames and control pulses
// compared every cycle against a queue-based model, plus directed scenarios.
`timescale 1ns/1ps
module tb_record;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int HALF   = 20;
  localparam logic [ADDR_W-1:0] AMAX = '1;
  localparam int M_IDLE = 0, M_WAIT = 1, M_SHIFT = 2, M_WRITE = 3, M_PAUSED = 4, M_DONE = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, pause = 1'b0, stop = 1'b0, lrc = 1'b1, dat = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr;
  logic              finish;
  logic [2:0]        state;
`ifdef RECORD_PEAK_EN
  logic [DATA_W-2:0] peak;
`endif

  record_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram ();

  record #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_start_addr(start_addr), .i_ADCLRC(lrc), .i_ADCDAT(dat), .sram(sram),
    .o_end_addr(end_addr), .o_finish(finish), .o_state(state)
`ifdef RECORD_PEAK_EN
    , .o_peak(peak)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                m_state = M_IDLE;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [ADDR_W-1:0] m_end   = '0;
  logic [DATA_W-1:0] m_data  = '0;
  bit                m_pend  = 1'b0;
  bit                m_prev  = 1'b0;
  bit                m_fall;
  bit                bits[$];
  int                m_peak  = 0;
  int                m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE; m_addr = '0; m_end = '0; m_data = '0;
      m_pend = 1'b0; m_prev = 1'b0; bits.delete(); m_peak = 0;
    end else begin
      m_fall = m_prev && !lrc;
      m_prev = lrc;
      case (m_state)
        M_IDLE: if (start && !stop) begin
          m_state = M_WAIT; m_addr = start_addr; m_pend = 1'b0; m_peak = 0;
        end
        M_WAIT: begin
          if (stop)        m_state = M_DONE;
          else if (pause)  m_state = M_PAUSED;
          else if (m_fall) begin bits.delete(); m_state = M_SHIFT; end
        end
        M_SHIFT: begin
          if (stop) m_state = M_DONE;
          else begin
            bits.push_back(dat);
            if (pause) m_pend = 1'b1;
            if (bits.size() == DATA_W) begin
              m_data = '0;
              foreach (bits[i]) m_data = {m_data[DATA_W-2:0], bits[i]};
              m_state = M_WRITE;
            end
          end
        end
        M_WRITE: begin
          m_end = m_addr;
          m_v = $signed(m_data);
          if (m_v < 0) m_v = -m_v;
          if (m_v > (1 << (DATA_W-1)) - 1) m_v = (1 << (DATA_W-1)) - 1;
          if (m_v > m_peak) m_peak = m_v;
          if (stop || m_addr == AMAX) m_state = M_DONE;
          else begin
            m_addr = m_addr + 1'b1;
            if (m_pend || pause) begin m_state = M_PAUSED; m_pend = 1'b0; end
            else m_state = M_WAIT;
          end
        end
        M_PAUSED: begin
          if (stop)                m_state = M_DONE;
          else if (start || pause) m_state = M_WAIT;
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare and write monitor ----------------
  logic [4:0]        exp_strb;
  logic [ADDR_W-1:0] wr_a[$];
  logic [DATA_W-1:0] wr_d[$];
  int                fin_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_strb = {m_state != M_WRITE, m_state == M_IDLE, 1'b1, m_state == M_IDLE, m_state == M_IDLE};
      check("state", state, m_state);
      check("addr", sram.o_sram_addr, m_addr);
      check("strobes", {sram.o_sram_we_n, sram.o_sram_ce_n, sram.o_sram_oe_n,
                        sram.o_sram_lb_n, sram.o_sram_ub_n}, exp_strb);
      check("end_addr", end_addr, m_end);
      check("finish", finish, m_state == M_DONE);
      if (m_state == M_WRITE) check("dq", sram.o_sram_dq, m_data);
`ifdef RECORD_PEAK_EN
      check("peak", peak, m_peak);
`endif
      if (sram.o_sram_we_n === 1'b0) begin
        wr_a.push_back(sram.o_sram_addr);
        wr_d.push_back(sram.o_sram_dq);
      end
      if (finish === 1'b1) fin_cnt++;
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a);
    start_addr = a; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0; tick(2);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] left, input logic [DATA_W-1:0] right,
                            input int pause_at);
    for (int i = 0; i < 2*HALF; i++) begin
      int k;
      k   = i % HALF;
      lrc = (i >= HALF);
      if (k >= 1 && k <= DATA_W) dat = (i < HALF) ? left[DATA_W-k] : right[DATA_W-k];
      else                       dat = 1'($urandom_range(0, 1));
      if (pause_at >= 0) pause = (i == pause_at);
      tick();
    end
    if (pause_at >= 0) pause = 1'b0;
  endtask

  int n0, f0;

  initial begin
    tick(2);
    rst_n = 1'b1;
    #1;
    check("reset state", state, 0);
    check("reset addr", sram.o_sram_addr, 0);
    check("reset ce_n", sram.o_sram_ce_n, 1);
    check("reset finish", finish, 0);
    tick();

    // Single left sample 0xAC54 at address 0.
    n0 = wr_a.size();
    pulse_start('0);
    send_frame(16'hAC54, 16'h1357, -1);
    #1;
    check("one write count", wr_a.size() - n0, 1);
    check("first write addr", wr_a[n0], 0);
    check("first write data", wr_d[n0], 16'hAC54);
    check("addr after write", sram.o_sram_addr, 1);
    pulse_stop();

    // Three frames then stop.
    n0 = wr_a.size(); f0 = fin_cnt;
    pulse_start('0);
    send_frame(16'h0001, 16'hFFFF, -1);
    send_frame(16'h8000, 16'h0000, -1);
    send_frame(16'hFFFF, 16'h8000, -1);
    pulse_stop();
    #1;
    check("three writes", wr_a.size() - n0, 3);
    check("w0 addr", wr_a[n0],   0);  check("w0 data", wr_d[n0],   16'h0001);
    check("w1 addr", wr_a[n0+1], 1);  check("w1 data", wr_d[n0+1], 16'h8000);
    check("w2 addr", wr_a[n0+2], 2);  check("w2 data", wr_d[n0+2], 16'hFFFF);
    check("end_addr after three", end_addr, 2);
    check("finish pulses", fin_cnt - f0, 1);
    tick();

    // Pause in the middle of shifting 0x1234.
    n0 = wr_a.size();
    pulse_start(20'h00100);
    send_frame(16'h1234, 16'h0F0F, 8);
    #1;
    check("paused state", state, 4);
    check("paused write data", wr_d[n0], 16'h1234);
    tick();
    send_frame(16'h9999, 16'h6666, -1);
    #1;
    check("paused frame ignored", wr_a.size() - n0, 1);
    tick();
    pulse_start('0);
    send_frame(16'h4321, 16'h2222, -1);
    #1;
    check("resume write addr", wr_a[n0+1], 20'h00101);
    check("resume write data", wr_d[n0+1], 16'h4321);
    tick();
    pulse_stop();

    // Last address: write then forced finish.
    n0 = wr_a.size(); f0 = fin_cnt;
    pulse_start(AMAX);
    send_frame(16'h5555, 16'hAAAA, -1);
    #1;
    check("top write addr", wr_a[n0], AMAX);
    check("top write data", wr_d[n0], 16'h5555);
    check("top finish", fin_cnt - f0, 1);
    check("top idle", state, 0);
    check("top end_addr", end_addr, AMAX);
    tick();

    // Reset in the middle of SHIFT.
    n0 = wr_a.size(); f0 = fin_cnt;
    pulse_start(20'h00200);
    lrc = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin dat = 1'($urandom_range(0, 1)); tick(); end
    #2 rst_n = 1'b0;
    #1;
    check("rst state", state, 0);
    check("rst addr", sram.o_sram_addr, 0);
    check("rst dq", sram.o_sram_dq, 0);
    check("rst strobes", {sram.o_sram_we_n, sram.o_sram_ce_n, sram.o_sram_oe_n,
                          sram.o_sram_lb_n, sram.o_sram_ub_n}, 5'b11111);
    check("rst end_addr", end_addr, 0);
    check("rst finish", finish, 0);
    tick(2);
    lrc = 1'b1;
    rst_n = 1'b1;
    tick(20);
    #1;
    check("rst no write", wr_a.size() - n0, 0);
    check("rst no finish", fin_cnt - f0, 0);
    tick();

    // Start and stop together in IDLE.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    #1;
    check("start+stop idle", state, 0);
    tick(3);
    #1;
    check("start+stop still idle", state, 0);
    tick();

`ifdef RECORD_PEAK_EN
    pulse_start('0);
    send_frame(16'h0100, 16'h0000, -1); #1; check("peak 0100", peak, 15'h0100); tick();
    send_frame(16'hFE00, 16'h0000, -1); #1; check("peak FE00", peak, 15'h0200); tick();
    send_frame(16'h8000, 16'h0000, -1); #1; check("peak 8000", peak, 15'h7FFF); tick();
    pulse_stop();
`endif

    // Randomized frames with random control pulses.
    fork
      begin
        for (int f = 0; f < 40; f++)
          send_frame(DATA_W'($urandom), DATA_W'($urandom), -1);
      end
      begin
        for (int c = 0; c < 40*2*HALF; c++) begin
          int r;
          r     = $urandom_range(0, 999);
          start = (r < 25);
          pause = (r >= 25 && r < 45);
          stop  = (r >= 45 && r < 50);
          if (start)
            start_addr = ($urandom_range(0, 3) == 0) ? AMAX - ADDR_W'($urandom_range(0, 2))
                                                    : ADDR_W'($urandom);
          tick();
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0;
      end
    join
    pulse_stop();
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
